// File: rtl/grid_pixel_scanner.sv
// Game-of-Life grid scanner: fetches one grid row per line from the banked grid
// BRAM and expands each cell into a CELL_PX x CELL_PX pixel square on a raster stream.
module grid_pixel_scanner #(
  parameter int          X_SIZE    = 640,
  parameter int          Y_SIZE    = 480,
  parameter int          GRID_COLS = 64,
  parameter int          GRID_ROWS = 48,
  parameter int          CELL_PX   = 10,
  parameter logic [23:0] ALIVE_RGB = 24'hCB416B,
  parameter logic [23:0] DEAD_RGB  = 24'h000000
) (
  input  logic                         out_stream_aclk,
  input  logic                         periph_resetn,
  input  logic                         enable,
  input  logic                         bank_sel,
  output logic [$clog2(GRID_ROWS):0]   grid_raddr,
  output logic                         grid_ren,
  input  logic [GRID_COLS-1:0]         grid_rdata,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b,
  output logic                         valid,
  input  logic                         ready,
  output logic                         sof,
  output logic                         eol,
  output logic                         frame_done,
  output logic                         busy
);
  localparam int XW = $clog2(X_SIZE);
  localparam int YW = $clog2(Y_SIZE);
  localparam int SW = $clog2(CELL_PX);
  localparam int CW = $clog2(GRID_COLS);
  localparam int RW = $clog2(GRID_ROWS);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_ST, STREAM} state_t;
  state_t state, state_nxt;

  logic                 bank_q;
  logic [XW-1:0]        x;
  logic [YW-1:0]        y;
  logic [SW-1:0]        sub_x, sub_y;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [GRID_COLS-1:0] line_q;
  logic                 accept, last_x, last_y, last_sx, last_sy;

  assign accept  = (state == STREAM) && ready;
  assign last_x  = (x == XW'(X_SIZE-1));
  assign last_y  = (y == YW'(Y_SIZE-1));
  assign last_sx = (sub_x == SW'(CELL_PX-1));
  assign last_sy = (sub_y == SW'(CELL_PX-1));

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = FETCH;
      FETCH:   state_nxt = WAIT_ST;
      WAIT_ST: state_nxt = STREAM;
      STREAM:  if (accept && last_x) state_nxt = (!last_y || enable) ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid      = (state == STREAM);
    busy       = (state != IDLE);
    grid_ren   = (state == FETCH);
    grid_raddr = '0;
    if (grid_ren) grid_raddr = {bank_q, row};
    {r, g, b}  = '0;
    sof        = 1'b0;
    eol        = 1'b0;
    if (valid) begin
      {r, g, b} = line_q[col] ? ALIVE_RGB : DEAD_RGB;
      sof       = (x == '0) && (y == '0);
      eol       = last_x;
    end
  end

  // Row is refetched every line; cell row advances every CELL_PX lines.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      bank_q     <= 1'b0;
      x          <= '0;
      y          <= '0;
      sub_x      <= '0;
      sub_y      <= '0;
      col        <= '0;
      row        <= '0;
      line_q     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_x && last_y;
      case (state)
        IDLE: if (enable) begin
          bank_q <= bank_sel;
          x      <= '0;
          y      <= '0;
          sub_x  <= '0;
          sub_y  <= '0;
          col    <= '0;
          row    <= '0;
        end
        WAIT_ST: line_q <= grid_rdata;
        STREAM: if (ready) begin
          if (last_x) begin
            x     <= '0;
            col   <= '0;
            sub_x <= '0;
            if (last_y) begin
              y     <= '0;
              sub_y <= '0;
              row   <= '0;
              if (enable) bank_q <= bank_sel;
            end else begin
              y <= y + 1'b1;
              if (last_sy) begin
                sub_y <= '0;
                row   <= row + 1'b1;
              end else begin
                sub_y <= sub_y + 1'b1;
              end
            end
          end else begin
            x <= x + 1'b1;
            if (last_sx) begin
              sub_x <= '0;
              col   <= col + 1'b1;
            end else begin
              sub_x <= sub_x + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
